// File: rtl/text_scroll_ctl.sv
// Clear/scroll engine for the 80x40 text RAM. It owns text RAM port B and shares it between
// the core operand bus and an internal fill/copy sequencer.
module text_scroll_ctl #(
  parameter logic [31:0] BASE     = 32'h0,
  parameter logic [31:0] CTL_ADDR = 32'h0,
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 40,
  parameter logic [7:0]  FILL     = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  localparam logic [31:0] NCells    = 32'(COLS * ROWS);
  localparam logic [11:0] LastCell  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LastCopy  = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] FillStart = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] RowStep   = 12'(COLS);

  typedef enum logic [2:0] {StIdle, StClr, StScRd, StScWr, StScFill} state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        busy_q, busy_d;
  logic        text_rd_q, text_rd_d;
  logic [1:0]  stat_q, stat_d;

  logic [31:0] cell_off;
  logic        is_ctl, ctl_wr, stat_rd, text_acc, idle, drop_ev, we_c;
  logic        unused_bits;

  // The control register takes priority should it ever overlap the text window.
  always_comb begin
    cell_off = cpu_addr - BASE;
    is_ctl   = cpu_en && (cpu_addr == CTL_ADDR);
    ctl_wr   = is_ctl && cpu_rw;
    stat_rd  = is_ctl && !cpu_rw;
    text_acc = cpu_en && !is_ctl && (cell_off < NCells);
    idle     = (state_q == StIdle);
    drop_ev  = !idle && (text_acc || ctl_wr);
  end

  assign unused_bits = ^{cpu_wdata[31:8], cell_off[31:12]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_addr  = 12'h0;
    ram_wdata = 8'h0;
    we_c      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (text_acc) begin
          ram_addr  = cell_off[11:0];
          ram_wdata = cpu_wdata[7:0];
          we_c      = cpu_rw;
        end
        if (ctl_wr && cpu_wdata[0]) begin
          state_d = StClr;
          cnt_d   = 12'h0;
        end else if (ctl_wr && cpu_wdata[1]) begin
          state_d = StScRd;
          cnt_d   = 12'h0;
        end
      end
      StClr, StScFill: begin
        ram_addr  = cnt_q;
        ram_wdata = FILL;
        we_c      = 1'b1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          cnt_d   = 12'h0;
        end else begin
          cnt_d = cnt_q + 12'h1;
        end
      end
      StScRd: begin
        ram_addr = cnt_q + RowStep;
        state_d  = StScWr;
      end
      StScWr: begin
        ram_addr  = cnt_q;
        ram_wdata = ram_rdata;
        we_c      = 1'b1;
        if (cnt_q == LastCopy) begin
          state_d = StScFill;
          cnt_d   = FillStart;
        end else begin
          state_d = StScRd;
          cnt_d   = cnt_q + 12'h1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 12'h0;
      end
    endcase
  end

  // A drop in the same cycle as a status read re-arms the sticky flag.
  always_comb begin
    drop_d    = (drop_q && !stat_rd) || drop_ev;
    busy_d    = (state_d != StIdle);
    text_rd_d = idle && text_acc && !cpu_rw;
    stat_d    = stat_rd ? {drop_q, busy_q} : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 12'h0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      text_rd_q <= 1'b0;
      stat_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      text_rd_q <= text_rd_d;
      stat_q    <= stat_d;
    end
  end

  assign ram_we    = we_c && reset_n;
  assign busy      = busy_q;
  assign cpu_rdata = text_rd_q ? {24'h0, ram_rdata} : {30'h0, stat_q};

endmodule

// File: tb/tb_text_scroll_ctl.sv
// Directed bench for text_scroll_ctl with a behavioural synchronous text RAM behind port B.
module tb_text_scroll_ctl;

  localparam logic [31:0] Base = 32'h10;
  localparam logic [31:0] Ctl  = 32'h3;
  localparam int          NCells = 3200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_en = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = 8'h0;
  logic        busy;

  logic [7:0]  mem [0:NCells-1];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  text_scroll_ctl #(
    .BASE     (Base),
    .CTL_ADDR (Ctl),
    .COLS     (80),
    .ROWS     (40),
    .FILL     (8'h20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_en    (cpu_en),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (int'(ram_addr) < NCells) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end else begin
      ram_rdata <= 8'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = addr; cpu_wdata = data;
    @(negedge clk);
    cpu_en = 1'b0; cpu_rw = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = addr;
    @(negedge clk);
    cpu_en = 1'b0;
    data = cpu_rdata;
  endtask

  // t0 is the cycle count just after the starting control write's edge.
  task automatic wait_idle(input string tag, input int t0, input int exp);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(cyc - t0), 32'(exp));
  endtask

  task automatic preload_const(input logic [7:0] v);
    for (int k = 0; k < NCells; k++) mem[k] = v;
  endtask

  task automatic preload_index;
    for (int k = 0; k < NCells; k++) mem[k] = 8'(k);
  endtask

  task automatic count_const(input logic [7:0] v, output int nb);
    nb = 0;
    for (int k = 0; k < NCells; k++) if (mem[k] !== v) nb++;
  endtask

  initial begin
    logic [31:0] rd;
    int          t0;
    int          nb;

    // Reset state
    #12;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_we", {31'h0, ram_we}, 32'h0);
    check_eq("rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    preload_const(8'h00);

    // Pass-through write then read of cell 5
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = Base + 32'd5; cpu_wdata = 32'h1234_5641;
    #1;
    check_eq("pt_we", {31'h0, ram_we}, 32'h1);
    check_eq("pt_addr", {20'h0, ram_addr}, 32'd5);
    check_eq("pt_wdata", {24'h0, ram_wdata}, 32'h41);
    @(negedge clk);
    cpu_en = 1'b0; cpu_rw = 1'b0;
    #1;
    check_eq("pt_we_off", {31'h0, ram_we}, 32'h0);
    check_eq("pt_mem", {24'h0, mem[5]}, 32'h41);
    cpu_rd(Base + 32'd5, rd);
    check_eq("pt_read", rd, 32'h41);

    // Out-of-range accesses are ignored
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = Base + 32'd3200; cpu_wdata = 32'h77;
    #1;
    check_eq("oor_hi_we", {31'h0, ram_we}, 32'h0);
    cpu_addr = Base - 32'd1;
    #1;
    check_eq("oor_lo_we", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    cpu_en = 1'b0; cpu_rw = 1'b0;
    cpu_rd(Base + 32'd3200, rd);
    check_eq("oor_read", rd, 32'h0);

    // A control write of zero starts nothing
    cpu_wr(Ctl, 32'h0);
    check_eq("ctl0_busy", {31'h0, busy}, 32'h0);

    // Clear
    preload_const(8'hAA);
    cpu_wr(Ctl, 32'h1);
    t0 = cyc;
    check_eq("clr_busy", {31'h0, busy}, 32'h1);
    wait_idle("clr_cycles", t0, 3200);
    count_const(8'h20, nb);
    check_eq("clr_cells", 32'(nb), 32'h0);
    cpu_rd(Ctl, rd);
    check_eq("clr_status", rd, 32'h0);

    // Scroll
    preload_index();
    cpu_wr(Ctl, 32'h2);
    t0 = cyc;
    wait_idle("scr_cycles", t0, 6320);
    nb = 0;
    for (int k = 0; k < NCells; k++) begin
      if (k < 3120) begin
        if (mem[k] !== 8'(k + 80)) nb++;
      end else if (mem[k] !== 8'h20) begin
        nb++;
      end
    end
    check_eq("scr_cells", 32'(nb), 32'h0);
    check_eq("scr_cell0", {24'h0, mem[0]}, 32'h50);

    // Collisions during a scroll
    preload_index();
    cpu_wr(Ctl, 32'h2);
    t0 = cyc;
    repeat (10) @(negedge clk);
    cpu_wr(Base, 32'h55);
    cpu_rd(Ctl, rd);
    check_eq("col_stat_busy", rd, 32'h3);
    cpu_wr(Ctl, 32'h1);
    wait_idle("col_cycles", t0, 6320);
    cpu_rd(Ctl, rd);
    check_eq("col_stat_done", rd, 32'h2);
    cpu_rd(Ctl, rd);
    check_eq("col_stat_clr", rd, 32'h0);
    check_eq("col_cell0", {24'h0, mem[0]}, 32'h50);
    check_eq("col_cell100", {24'h0, mem[100]}, 32'hB4);
    check_eq("col_cell3150", {24'h0, mem[3150]}, 32'h20);

    // Both bits set: clear wins
    preload_const(8'hAA);
    cpu_wr(Ctl, 32'h3);
    t0 = cyc;
    wait_idle("pri_cycles", t0, 3200);
    count_const(8'h20, nb);
    check_eq("pri_cells", 32'(nb), 32'h0);

    // Asynchronous reset in the middle of a clear, with a status read in flight
    preload_const(8'hAA);
    cpu_wr(Ctl, 32'h1);
    repeat (20) @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = Ctl;
    @(posedge clk);
    #2;
    check_eq("pre_rst_rdata", cpu_rdata, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("mid_rst_we", {31'h0, ram_we}, 32'h0);
    check_eq("mid_rst_rdata", cpu_rdata, 32'h0);
    cpu_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("post_rst_cell", {24'h0, mem[1000]}, 32'hAA);
    cpu_rd(Ctl, rd);
    check_eq("post_rst_stat", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
